core_mem_arbiter: RTL and testbench

N-to-1 arbiter that shares one slave memory port (req/gnt/rvalid core protocol) among NUM_MASTERS core-side masters. Round-robin grant selection. Request fields are held stable toward the slave until grant. Grantee IDs are recorded in an in-order FIFO so that each rvalid/rdata is routed back to the correct master. Sits between core/DMA LSU ports and a single memory or bus slave.

---
 rtl/core_arb_pkg.sv | 47 ++++
 rtl/core_arb_id_fifo.sv | 65 ++++++
 rtl/core_mem_arbiter.sv | 143 ++++++++++++++
 tb/tb_core_mem_arbiter.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/core_arb_pkg.sv
// ============================================================================
// Module      : core_arb_pkg
// Description : Shared types and helpers for the core memory arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package core_arb_pkg;

    localparam int c_MAX_MASTERS = 16;

    function automatic int id_w(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

    localparam int c_ID_W_MAX = id_w(c_MAX_MASTERS);

    // Master IDs are carried at the widest supported width so every user shares one type.
    typedef logic [c_ID_W_MAX-1:0] master_id_t;

    typedef struct packed {
        logic       found;
        master_id_t id;
    } rr_pick_t;

    // First requester at or after ptr, wrapping within the n populated masters.
    function automatic rr_pick_t rr_pick(
        input logic [c_MAX_MASTERS-1:0] req,
        input master_id_t               ptr,
        input int                       n
    );
        rr_pick_t pick;
        int       idx;
        pick = '0;
        for (int k = 0; k < c_MAX_MASTERS; k++) begin
            idx = (int'(ptr) + k) % n;
            if ((k < n) && !pick.found && req[master_id_t'(idx)]) begin
                pick.found = 1'b1;
                pick.id    = master_id_t'(idx);
            end
        end
        return pick;
    endfunction

endpackage

`default_nettype wire

// File: rtl/core_arb_id_fifo.sv
// ============================================================================
// Module      : core_arb_id_fifo
// Description : In-order FIFO of granted master IDs used to route responses.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_arb_id_fifo
    import core_arb_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       push,
    input  master_id_t                 push_id,
    input  logic                       pop,
    output master_id_t                 head_id,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int c_PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int c_CNT_W = $clog2(DEPTH + 1);

    master_id_t           r_mem [DEPTH];
    logic [c_PTR_W-1:0]   r_wr_ptr;
    logic [c_PTR_W-1:0]   r_rd_ptr;
    logic [c_CNT_W-1:0]   r_count;
    logic                 w_do_push;
    logic                 w_do_pop;

    function automatic logic [c_PTR_W-1:0] ptr_inc(input logic [c_PTR_W-1:0] p);
        return (p == c_PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full      = (r_count == c_CNT_W'(DEPTH));
    assign empty     = (r_count == '0);
    assign count     = r_count;
    assign head_id   = r_mem[r_rd_ptr];
    assign w_do_push = push & ~full;
    assign w_do_pop  = pop & ~empty;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_do_push) r_wr_ptr <= ptr_inc(r_wr_ptr);
            if (w_do_pop)  r_rd_ptr <= ptr_inc(r_rd_ptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end

    // Storage carries no reset; contents are only read while count is nonzero.
    always_ff @(posedge clk) begin
        if (w_do_push) r_mem[r_wr_ptr] <= push_id;
    end

endmodule

`default_nettype wire

// File: rtl/core_mem_arbiter.sv
// ============================================================================
// Module      : core_mem_arbiter
// Description : Round-robin N-to-1 arbiter for a req/gnt/rvalid memory port.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module core_mem_arbiter
    import core_arb_pkg::*;
#(
    parameter int NUM_MASTERS = 4,
    parameter int ADDR_WIDTH  = 32,
    parameter int DATA_WIDTH  = 32,
    parameter int BE_WIDTH    = 4,
    parameter int MAX_OUTST   = 4
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic [NUM_MASTERS-1:0]            m_req,
    input  logic [NUM_MASTERS*ADDR_WIDTH-1:0] m_addr,
    input  logic [NUM_MASTERS-1:0]            m_we,
    input  logic [NUM_MASTERS*BE_WIDTH-1:0]   m_be,
    input  logic [NUM_MASTERS*DATA_WIDTH-1:0] m_wdata,
    output logic [NUM_MASTERS-1:0]            m_gnt,
    output logic [NUM_MASTERS-1:0]            m_rvalid,
    output logic [DATA_WIDTH-1:0]             m_rdata,
    output logic                              s_req,
    output logic [ADDR_WIDTH-1:0]             s_addr,
    output logic                              s_we,
    output logic [BE_WIDTH-1:0]               s_be,
    output logic [DATA_WIDTH-1:0]             s_wdata,
    input  logic                              s_gnt,
    input  logic                              s_rvalid,
    input  logic [DATA_WIDTH-1:0]             s_rdata,
    output logic [$clog2(MAX_OUTST+1)-1:0]    outst_cnt,
    output logic                              err
);

    logic [c_MAX_MASTERS-1:0] w_req_ext;
    logic [c_MAX_MASTERS-1:0] w_we_ext;
    logic [ADDR_WIDTH-1:0]    w_addr  [c_MAX_MASTERS];
    logic [BE_WIDTH-1:0]      w_be    [c_MAX_MASTERS];
    logic [DATA_WIDTH-1:0]    w_wdata [c_MAX_MASTERS];

    // Widen the packed buses to the maximum master count so a full-width ID indexes them safely.
    for (genvar i = 0; i < c_MAX_MASTERS; i++) begin : g_unpack
        if (i < NUM_MASTERS) begin : g_used
            assign w_req_ext[i] = m_req[i];
            assign w_we_ext[i]  = m_we[i];
            assign w_addr[i]    = m_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
            assign w_be[i]      = m_be[i*BE_WIDTH +: BE_WIDTH];
            assign w_wdata[i]   = m_wdata[i*DATA_WIDTH +: DATA_WIDTH];
        end else begin : g_unused
            assign w_req_ext[i] = 1'b0;
            assign w_we_ext[i]  = 1'b0;
            assign w_addr[i]    = '0;
            assign w_be[i]      = '0;
            assign w_wdata[i]   = '0;
        end
    end

    logic       r_lock;
    master_id_t r_lock_id;
    master_id_t r_rr_ptr;
    logic       r_err;

    rr_pick_t   w_pick;
    master_id_t w_sel;
    master_id_t w_sel_next;
    master_id_t w_head;
    logic       w_full;
    logic       w_empty;
    logic       w_s_req;
    logic       w_push;
    logic       w_pop;
    logic       w_lock_drop;

    always_comb begin
        w_pick      = rr_pick(w_req_ext, r_rr_ptr, NUM_MASTERS);
        w_sel       = r_lock ? r_lock_id : (w_pick.found ? w_pick.id : r_rr_ptr);
        w_sel_next  = (w_sel == master_id_t'(NUM_MASTERS - 1)) ? '0 : w_sel + 1'b1;
        // Full blocks requests outright; an rvalid in the same cycle does not reopen the path.
        w_s_req     = rst & w_req_ext[w_sel] & ~w_full;
        w_push      = w_s_req & s_gnt;
        w_pop       = rst & s_rvalid & ~w_empty;
        w_lock_drop = r_lock & ~w_req_ext[r_lock_id];
    end

    always_comb begin
        m_gnt    = '0;
        m_rvalid = '0;
        for (int i = 0; i < NUM_MASTERS; i++) begin
            if (w_push && (w_sel == master_id_t'(i)))  m_gnt[i]    = 1'b1;
            if (w_pop && (w_head == master_id_t'(i)))  m_rvalid[i] = 1'b1;
        end
    end

    assign s_req   = w_s_req;
    assign s_addr  = w_addr[w_sel];
    assign s_we    = w_we_ext[w_sel];
    assign s_be    = w_be[w_sel];
    assign s_wdata = w_wdata[w_sel];
    assign m_rdata = s_rdata;
    assign err     = r_err;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_lock    <= 1'b0;
            r_lock_id <= '0;
            r_rr_ptr  <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_push) begin
                r_lock   <= 1'b0;
                r_rr_ptr <= w_sel_next;
            end else if (w_lock_drop) begin
                r_lock <= 1'b0;
            end else if (w_s_req) begin
                r_lock    <= 1'b1;
                r_lock_id <= w_sel;
            end
            if (w_lock_drop || (s_gnt && !w_s_req) || (s_rvalid && w_empty))
                r_err <= 1'b1;
        end
    end

    core_arb_id_fifo #(
        .DEPTH (MAX_OUTST)
    ) u_id_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (w_push),
        .push_id (w_sel),
        .pop     (w_pop),
        .head_id (w_head),
        .full    (w_full),
        .empty   (w_empty),
        .count   (outst_cnt)
    );

endmodule

`default_nettype wire

// File: tb/tb_core_mem_arbiter.sv
// ============================================================================
// Module      : tb_core_mem_arbiter
// Description : Directed self-checking bench for core_mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_core_mem_arbiter;

    localparam int N  = 4;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int BW = 4;
    localparam int MO = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [N-1:0]  m_req;
    logic [N*AW-1:0] m_addr;
    logic [N-1:0]  m_we;
    logic [N*BW-1:0] m_be;
    logic [N*DW-1:0] m_wdata;
    logic [N-1:0]  m_gnt;
    logic [N-1:0]  m_rvalid;
    logic [DW-1:0] m_rdata;
    logic          s_req;
    logic [AW-1:0] s_addr;
    logic          s_we;
    logic [BW-1:0] s_be;
    logic [DW-1:0] s_wdata;
    logic          s_gnt;
    logic          s_rvalid;
    logic [DW-1:0] s_rdata;
    logic [2:0]    outst_cnt;
    logic          err;

    int vecs  = 0;
    int fails = 0;

    always #5 clk = ~clk;

    core_mem_arbiter #(
        .NUM_MASTERS (N), .ADDR_WIDTH (AW), .DATA_WIDTH (DW), .BE_WIDTH (BW), .MAX_OUTST (MO)
    ) dut (
        .clk (clk), .rst (rst),
        .m_req (m_req), .m_addr (m_addr), .m_we (m_we), .m_be (m_be), .m_wdata (m_wdata),
        .m_gnt (m_gnt), .m_rvalid (m_rvalid), .m_rdata (m_rdata),
        .s_req (s_req), .s_addr (s_addr), .s_we (s_we), .s_be (s_be), .s_wdata (s_wdata),
        .s_gnt (s_gnt), .s_rvalid (s_rvalid), .s_rdata (s_rdata),
        .outst_cnt (outst_cnt), .err (err)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b0; m_req = 4'b1111; s_gnt = 1'b1; s_rvalid = 1'b1;
        #2;
        vecs++; if (s_req !== 1'b0)     begin fails++; $display("FAIL rst_s_req: got %b want 0", s_req); end
        vecs++; if (m_gnt !== 4'b0000)  begin fails++; $display("FAIL rst_m_gnt: got %b want 0000", m_gnt); end
        vecs++; if (m_rvalid !== 4'b0)  begin fails++; $display("FAIL rst_m_rvalid: got %b want 0000", m_rvalid); end
        vecs++; if (outst_cnt !== 3'd0) begin fails++; $display("FAIL rst_outst: got %0d want 0", outst_cnt); end
        vecs++; if (err !== 1'b0)       begin fails++; $display("FAIL rst_err: got %b want 0", err); end
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        step();
    endtask

    task automatic test_basic_rr();
        m_req = 4'b0101; s_gnt = 1'b1; #1;
        vecs++; if (m_gnt !== 4'b0001)        begin fails++; $display("FAIL rr_gnt_m0: got %b want 0001", m_gnt); end
        vecs++; if (s_addr !== 32'h1000_0000) begin fails++; $display("FAIL rr_addr_m0: got %h want 10000000", s_addr); end
        step(); #1;
        vecs++; if (m_gnt !== 4'b0100)        begin fails++; $display("FAIL rr_gnt_m2: got %b want 0100", m_gnt); end
        vecs++; if (s_addr !== 32'h1000_0020) begin fails++; $display("FAIL rr_addr_m2: got %h want 10000020", s_addr); end
        vecs++; if ({s_we, s_be, s_wdata} !== {1'b1, 4'h3, 32'hD000_0002})
            begin fails++; $display("FAIL rr_fields_m2: got %b %h %h want 1 3 d0000002", s_we, s_be, s_wdata); end
        step();
        m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; s_rdata = 32'h1111_0000; #1;
        vecs++; if (outst_cnt !== 3'd2)       begin fails++; $display("FAIL rr_outst2: got %0d want 2", outst_cnt); end
        vecs++; if (m_rvalid !== 4'b0001)     begin fails++; $display("FAIL rr_rvalid_m0: got %b want 0001", m_rvalid); end
        step(); s_rdata = 32'h1111_0002; #1;
        vecs++; if (m_rvalid !== 4'b0100)     begin fails++; $display("FAIL rr_rvalid_m2: got %b want 0100", m_rvalid); end
        step(); s_rvalid = 1'b0; #1;
        vecs++; if (outst_cnt !== 3'd0)       begin fails++; $display("FAIL rr_outst0: got %0d want 0", outst_cnt); end
        step();
    endtask

    task automatic test_lock_hold();
        m_req = 4'b0010; s_gnt = 1'b0; #1;
        vecs++; if (s_req !== 1'b1 || s_addr !== 32'h1000_0010)
            begin fails++; $display("FAIL lock_c1: got req %b addr %h want 1 10000010", s_req, s_addr); end
        step(); m_req = 4'b1010; #1;
        vecs++; if (s_addr !== 32'h1000_0010) begin fails++; $display("FAIL lock_c2_addr: got %h want 10000010", s_addr); end
        step(); #1;
        vecs++; if (s_addr !== 32'h1000_0010 || m_gnt !== 4'b0000)
            begin fails++; $display("FAIL lock_c3: got addr %h gnt %b want 10000010 0000", s_addr, m_gnt); end
        step(); s_gnt = 1'b1; #1;
        vecs++; if (m_gnt !== 4'b0010)        begin fails++; $display("FAIL lock_gnt_m1: got %b want 0010", m_gnt); end
        step(); m_req = 4'b1000; #1;
        vecs++; if (m_gnt !== 4'b1000 || s_addr !== 32'h1000_0030)
            begin fails++; $display("FAIL lock_gnt_m3: got gnt %b addr %h want 1000 10000030", m_gnt, s_addr); end
        step(); m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1; #1;
        vecs++; if (m_rvalid !== 4'b0010)     begin fails++; $display("FAIL lock_rv_m1: got %b want 0010", m_rvalid); end
        step(); #1;
        vecs++; if (m_rvalid !== 4'b1000)     begin fails++; $display("FAIL lock_rv_m3: got %b want 1000", m_rvalid); end
        step(); s_rvalid = 1'b0;
        step();
    endtask

    task automatic test_full();
        logic [3:0] exp_ord [4];
        logic [3:0] want;
        exp_ord = '{4'b0010, 4'b0100, 4'b1000, 4'b0001};
        m_req = 4'b1111; s_gnt = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            want = 4'b0001 << k;
            vecs++; if (m_gnt !== want) begin fails++; $display("FAIL full_gnt%0d: got %b want %b", k, m_gnt, want); end
            step();
        end
        s_gnt = 1'b0; #1;
        vecs++; if (s_req !== 1'b0 || outst_cnt !== 3'd4)
            begin fails++; $display("FAIL full_block: got req %b cnt %0d want 0 4", s_req, outst_cnt); end
        step(); s_rvalid = 1'b1; s_rdata = 32'hA5A5_0001; #1;
        vecs++; if (m_rvalid !== 4'b0001 || m_rdata !== 32'hA5A5_0001 || s_req !== 1'b0)
            begin fails++; $display("FAIL full_pop: got rv %b data %h req %b want 0001 a5a50001 0", m_rvalid, m_rdata, s_req); end
        step(); s_rvalid = 1'b0; s_gnt = 1'b1; #1;
        vecs++; if (s_req !== 1'b1 || outst_cnt !== 3'd3 || m_gnt !== 4'b0001)
            begin fails++; $display("FAIL full_reopen: got req %b cnt %0d gnt %b want 1 3 0001", s_req, outst_cnt, m_gnt); end
        step(); m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            #1;
            vecs++; if (m_rvalid !== exp_ord[k])
                begin fails++; $display("FAIL full_drain%0d: got %b want %b", k, m_rvalid, exp_ord[k]); end
            step();
        end
        s_rvalid = 1'b0; #1;
        vecs++; if (outst_cnt !== 3'd0)       begin fails++; $display("FAIL full_empty: got %0d want 0", outst_cnt); end
        step();
    endtask

    task automatic test_back_to_back();
        m_req = 4'b0010; s_gnt = 1'b1; #1;
        vecs++; if (m_gnt !== 4'b0010)        begin fails++; $display("FAIL b2b_gnt_m1: got %b want 0010", m_gnt); end
        step(); m_req = 4'b0100; s_rvalid = 1'b1; s_rdata = 32'hBEEF_0004; #1;
        vecs++; if (m_rvalid !== 4'b0010 || m_gnt !== 4'b0100 || outst_cnt !== 3'd1)
            begin fails++; $display("FAIL b2b_both: got rv %b gnt %b cnt %0d want 0010 0100 1", m_rvalid, m_gnt, outst_cnt); end
        step(); m_req = '0; s_gnt = 1'b0; #1;
        vecs++; if (outst_cnt !== 3'd1 || m_rvalid !== 4'b0100)
            begin fails++; $display("FAIL b2b_after: got cnt %0d rv %b want 1 0100", outst_cnt, m_rvalid); end
        step(); s_rvalid = 1'b0; #1;
        vecs++; if (outst_cnt !== 3'd0 || err !== 1'b0)
            begin fails++; $display("FAIL b2b_end: got cnt %0d err %b want 0 0", outst_cnt, err); end
        step();
    endtask

    task automatic test_orphan_rvalid();
        s_rvalid = 1'b1; #1;
        vecs++; if (m_rvalid !== 4'b0000)     begin fails++; $display("FAIL orph_rv: got %b want 0000", m_rvalid); end
        step(); s_rvalid = 1'b0; #1;
        vecs++; if (err !== 1'b1 || outst_cnt !== 3'd0)
            begin fails++; $display("FAIL orph_err: got err %b cnt %0d want 1 0", err, outst_cnt); end
        step(); step(); #1;
        vecs++; if (err !== 1'b1)             begin fails++; $display("FAIL orph_sticky: got %b want 1", err); end
        step();
    endtask

    task automatic test_async_reset();
        m_req = 4'b0011; s_gnt = 1'b1; #1;
        vecs++; if (m_gnt !== 4'b0001)        begin fails++; $display("FAIL ar_gnt_m0: got %b want 0001", m_gnt); end
        step(); #1;
        vecs++; if (m_gnt !== 4'b0010)        begin fails++; $display("FAIL ar_gnt_m1: got %b want 0010", m_gnt); end
        step(); m_req = 4'b1111; s_gnt = 1'b0; s_rvalid = 1'b1; #1;
        vecs++; if (outst_cnt !== 3'd2)       begin fails++; $display("FAIL ar_pre_cnt: got %0d want 2", outst_cnt); end
        s_rvalid = 1'b0; s_gnt = 1'b1; #1;
        rst = 1'b0; #1;
        vecs++; if (s_req !== 1'b0 || m_gnt !== 4'b0 || outst_cnt !== 3'd0 || err !== 1'b0)
            begin fails++; $display("FAIL ar_async: got req %b gnt %b cnt %0d err %b want 0 0000 0 0", s_req, m_gnt, outst_cnt, err); end
        s_rvalid = 1'b1; #1;
        vecs++; if (m_rvalid !== 4'b0000)     begin fails++; $display("FAIL ar_rv_in_rst: got %b want 0000", m_rvalid); end
        m_req = '0; s_gnt = 1'b0;
        @(negedge clk);
        rst = 1'b1; #1;
        vecs++; if (m_rvalid !== 4'b0000)     begin fails++; $display("FAIL ar_late_rv: got %b want 0000", m_rvalid); end
        step(); s_rvalid = 1'b0; #1;
        vecs++; if (err !== 1'b1)             begin fails++; $display("FAIL ar_late_err: got %b want 1", err); end
        m_req = 4'b1111; s_gnt = 1'b1; #1;
        vecs++; if (m_gnt !== 4'b0001)        begin fails++; $display("FAIL ar_restart_m0: got %b want 0001", m_gnt); end
        step(); m_req = '0; s_gnt = 1'b0; s_rvalid = 1'b1;
        step(); s_rvalid = 1'b0; #1;
        vecs++; if (outst_cnt !== 3'd0)       begin fails++; $display("FAIL ar_drain: got %0d want 0", outst_cnt); end
        step();
    endtask

    task automatic test_lock_drop();
        rst = 1'b0; #1; rst = 1'b1; #1;
        vecs++; if (err !== 1'b0)             begin fails++; $display("FAIL ld_err_clr: got %b want 0", err); end
        m_req = 4'b0001; s_gnt = 1'b0; #1;
        vecs++; if (s_req !== 1'b1)           begin fails++; $display("FAIL ld_req: got %b want 1", s_req); end
        step(); m_req = '0; #1;
        vecs++; if (s_req !== 1'b0 || err !== 1'b0)
            begin fails++; $display("FAIL ld_drop: got req %b err %b want 0 0", s_req, err); end
        step(); #1;
        vecs++; if (err !== 1'b1)             begin fails++; $display("FAIL ld_err: got %b want 1", err); end
        rst = 1'b0; #1; rst = 1'b1; #1;
        s_gnt = 1'b1;
        step(); s_gnt = 1'b0; #1;
        vecs++; if (err !== 1'b1)             begin fails++; $display("FAIL gnt_noreq_err: got %b want 1", err); end
        step();
    endtask

    initial begin
        m_req = '0; m_we = 4'b0100; s_gnt = 1'b0; s_rvalid = 1'b0; s_rdata = '0;
        for (int i = 0; i < N; i++) begin
            m_addr[i*AW +: AW]  = 32'h1000_0000 + 32'(i) * 32'h10;
            m_wdata[i*DW +: DW] = 32'hD000_0000 + 32'(i);
            m_be[i*BW +: BW]    = BW'(i + 1);
        end
        test_reset();
        test_basic_rr();
        test_lock_hold();
        test_full();
        test_back_to_back();
        test_orphan_rvalid();
        test_async_reset();
        test_lock_drop();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, fails);
        $finish;
    end

endmodule

`default_nettype wire
